// File: rtl/aucohl_fifo_wr_arb.sv
// Round-robin write arbiter feeding one downstream FIFO. N requesters each
// present a level request and a data word. A winner may keep the FIFO for up
// to burst_len consecutive beats. Backpressure (fifo_full) or en=0 freezes
// all state. Strobes and write data are combinational; owner and busy are
// registered.
module aucohl_fifo_wr_arb #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int BW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [BW-1:0]   burst_len,
  input  logic [N-1:0]    req,
  input  logic [N*DW-1:0] req_data,
  output logic [N-1:0]    ack,
  input  logic            fifo_full,
  output logic            fifo_wr,
  output logic [DW-1:0]   fifo_wdata,
  output logic [N-1:0]    owner,
  output logic            busy
);

  localparam int LW = $clog2(N);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t         r_state, w_state_next;
  logic [LW-1:0]  r_last, w_last_next;
  logic [BW-1:0]  r_beats, w_beats_next;
  logic [BW-1:0]  r_blen, w_blen_next;
  logic [N-1:0]   r_owner, w_owner_next;

  logic           w_accept;
  logic [BW-1:0]  w_blen_eff;
  logic [BW-1:0]  w_beats_inc;
  logic           w_owner_req;
  logic [LW-1:0]  w_cand [N];
  logic           w_found;
  logic [LW-1:0]  w_win;
  logic [N-1:0]   w_win_oh;
  logic [N-1:0]   w_ack;
  logic [DW-1:0]  w_wdata;

  // rst_n is part of accept so the strobes drop the moment reset asserts.
  assign w_accept    = en & ~fifo_full & rst_n;
  assign w_blen_eff  = (burst_len == '0) ? BW'(1) : burst_len;
  assign w_beats_inc = r_beats + BW'(1);
  assign w_owner_req = |(req & r_owner);
  assign w_win_oh    = N'(1) << w_win;

  // Candidate k is requester (last + 1 + k) mod N, i.e. the search order.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      logic [LW:0] w_sum;
      assign w_sum       = {1'b0, r_last} + (LW+1)'(gi + 1);
      assign w_cand[gi]  = (w_sum >= (LW+1)'(N)) ? LW'(w_sum - (LW+1)'(N))
                                                  : w_sum[LW-1:0];
    end
  endgenerate

  // First requesting candidate in rotation order wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && req[w_cand[k]]) begin
        w_found = 1'b1;
        w_win   = w_cand[k];
      end
    end
  end

  // Next-state and strobe logic: continue the burst while the owner still
  // requests, otherwise arbitrate (an owner dropping req ends its burst).
  always_comb begin
    w_state_next = r_state;
    w_last_next  = r_last;
    w_beats_next = r_beats;
    w_blen_next  = r_blen;
    w_owner_next = r_owner;
    w_ack        = '0;
    if (w_accept) begin
      if (r_state == S_BURST && w_owner_req) begin
        w_ack        = r_owner;
        w_beats_next = w_beats_inc;
        if (w_beats_inc == r_blen) begin
          w_state_next = S_IDLE;
          w_owner_next = '0;
          w_beats_next = '0;
        end
      end else begin
        w_state_next = S_IDLE;
        w_owner_next = '0;
        w_beats_next = '0;
        if (w_found) begin
          w_ack       = w_win_oh;
          w_last_next = w_win;
          if (w_blen_eff > BW'(1)) begin
            w_state_next = S_BURST;
            w_owner_next = w_win_oh;
            w_beats_next = BW'(1);
            w_blen_next  = w_blen_eff;
          end
        end
      end
    end
  end

  // AND-OR mux of the acked requester's data; zero when nothing is written.
  always_comb begin
    w_wdata = '0;
    for (int i = 0; i < N; i++) begin
      if (w_ack[i]) w_wdata = w_wdata | req_data[i*DW +: DW];
    end
  end

  // State registers; reset leaves last at N-1 so the first search starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_last  <= LW'(N - 1);
      r_beats <= '0;
      r_blen  <= BW'(1);
      r_owner <= '0;
    end else begin
      r_state <= w_state_next;
      r_last  <= w_last_next;
      r_beats <= w_beats_next;
      r_blen  <= w_blen_next;
      r_owner <= w_owner_next;
    end
  end

  assign ack        = w_ack;
  assign fifo_wr    = |w_ack;
  assign fifo_wdata = w_wdata;
  assign owner      = r_owner;
  assign busy       = (r_state == S_BURST);

endmodule

// File: tb/tb_aucohl_fifo_wr_arb.sv
// Directed bench for aucohl_fifo_wr_arb (N=4, DW=8, BW=4). Inputs change 1ns
// after the rising edge; outputs are checked on the falling edge.
module tb_aucohl_fifo_wr_arb;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [3:0]  burst_len;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        fifo_full;
  logic        fifo_wr;
  logic [7:0]  fifo_wdata;
  logic [3:0]  owner;
  logic        busy;

  int total = 0;
  int bad   = 0;

  aucohl_fifo_wr_arb #(.N(4), .DW(8), .BW(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .burst_len  (burst_len),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .fifo_full  (fifo_full),
    .fifo_wr    (fifo_wr),
    .fifo_wdata (fifo_wdata),
    .owner      (owner),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at posedge+1; pulses reset for one cycle and returns at posedge+1.
  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; req = 4'hF; burst_len = 4'd1; fifo_full = 1'b0;
    #2;
    for (int c = 0; c < 2; c++) begin
      total++; if (ack !== 4'b0000) begin bad++; $display("FAIL reset_ack c=%0d got=%b exp=0000", c, ack); end
      total++; if (fifo_wr !== 1'b0) begin bad++; $display("FAIL reset_wr c=%0d got=%b exp=0", c, fifo_wr); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy c=%0d got=%b exp=0", c, busy); end
      total++; if (owner !== 4'b0000) begin bad++; $display("FAIL reset_owner c=%0d got=%b exp=0000", c, owner); end
      total++; if (fifo_wdata !== 8'h00) begin bad++; $display("FAIL reset_wdata c=%0d got=%h exp=00", c, fifo_wdata); end
      $display("reset c=%0d ack=%b wr=%b busy=%b", c, ack, fifo_wr, busy);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (ack !== 4'b0001) begin bad++; $display("FAIL reset_first_ack got=%b exp=0001", ack); end
    total++; if (fifo_wdata !== 8'hA0) begin bad++; $display("FAIL reset_first_data got=%h exp=a0", fifo_wdata); end
    $display("reset release ack=%b data=%h", ack, fifo_wdata);
    @(posedge clk); #1;
  endtask

  task automatic test_rotation();
    logic [3:0] ea;
    logic [7:0] ed;
    do_reset();
    en = 1'b1; burst_len = 4'd1; req = 4'hF; fifo_full = 1'b0;
    for (int c = 0; c < 8; c++) begin
      ea = 4'b0001 << (c % 4);
      ed = 8'hA0 + 8'(c % 4);
      @(negedge clk);
      total++; if (ack !== ea) begin bad++; $display("FAIL rot_ack c=%0d got=%b exp=%b", c, ack, ea); end
      total++; if (fifo_wdata !== ed) begin bad++; $display("FAIL rot_data c=%0d got=%h exp=%h", c, fifo_wdata, ed); end
      total++; if (fifo_wr !== 1'b1) begin bad++; $display("FAIL rot_wr c=%0d got=%b exp=1", c, fifo_wr); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rot_busy c=%0d got=%b exp=0", c, busy); end
      $display("rotation c=%0d ack=%b data=%h", c, ack, fifo_wdata);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_burst();
    logic [3:0] ea [9];
    logic       eb [9];
    logic [3:0] eo [9];
    ea = '{4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h1, 4'h1, 4'h1};
    eb = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    eo = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h1, 4'h1};
    do_reset();
    en = 1'b1; burst_len = 4'd3; req = 4'b0011; fifo_full = 1'b0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      total++; if (ack !== ea[c]) begin bad++; $display("FAIL burst_ack c=%0d got=%b exp=%b", c, ack, ea[c]); end
      total++; if (busy !== eb[c]) begin bad++; $display("FAIL burst_busy c=%0d got=%b exp=%b", c, busy, eb[c]); end
      total++; if (owner !== eo[c]) begin bad++; $display("FAIL burst_owner c=%0d got=%b exp=%b", c, owner, eo[c]); end
      $display("burst c=%0d ack=%b busy=%b owner=%b", c, ack, busy, owner);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic       ef [6];
    logic [3:0] ea [6];
    logic [3:0] eo [6];
    logic       eb [6];
    ef = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    ea = '{4'h1, 4'h1, 4'h0, 4'h0, 4'h1, 4'h2};
    eo = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0};
    eb = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    en = 1'b1; burst_len = 4'd3; req = 4'b0011;
    for (int c = 0; c < 6; c++) begin
      fifo_full = ef[c];
      @(negedge clk);
      total++; if (ack !== ea[c]) begin bad++; $display("FAIL bp_ack c=%0d got=%b exp=%b", c, ack, ea[c]); end
      total++; if (fifo_wr !== (ea[c] != 4'h0)) begin bad++; $display("FAIL bp_wr c=%0d got=%b exp=%b", c, fifo_wr, (ea[c] != 4'h0)); end
      total++; if (owner !== eo[c]) begin bad++; $display("FAIL bp_owner c=%0d got=%b exp=%b", c, owner, eo[c]); end
      total++; if (busy !== eb[c]) begin bad++; $display("FAIL bp_busy c=%0d got=%b exp=%b", c, busy, eb[c]); end
      if (ef[c]) begin
        total++; if (fifo_wdata !== 8'h00) begin bad++; $display("FAIL bp_wdata c=%0d got=%h exp=00", c, fifo_wdata); end
      end
      $display("backpressure c=%0d full=%b ack=%b owner=%b busy=%b", c, fifo_full, ack, owner, busy);
      @(posedge clk); #1;
    end
    fifo_full = 1'b0;
  endtask

  task automatic test_early_release();
    logic [3:0] er [3];
    logic [3:0] ea [3];
    logic       eb [3];
    logic [3:0] eo [3];
    logic [7:0] ed [3];
    er = '{4'b0101, 4'b0100, 4'b0100};
    ea = '{4'h1, 4'h4, 4'h4};
    eb = '{1'b0, 1'b1, 1'b1};
    eo = '{4'h0, 4'h1, 4'h4};
    ed = '{8'hA0, 8'hA2, 8'hA2};
    do_reset();
    en = 1'b1; burst_len = 4'd3; fifo_full = 1'b0;
    for (int c = 0; c < 3; c++) begin
      req = er[c];
      @(negedge clk);
      total++; if (ack !== ea[c]) begin bad++; $display("FAIL early_ack c=%0d got=%b exp=%b", c, ack, ea[c]); end
      total++; if (busy !== eb[c]) begin bad++; $display("FAIL early_busy c=%0d got=%b exp=%b", c, busy, eb[c]); end
      total++; if (owner !== eo[c]) begin bad++; $display("FAIL early_owner c=%0d got=%b exp=%b", c, owner, eo[c]); end
      total++; if (fifo_wdata !== ed[c]) begin bad++; $display("FAIL early_data c=%0d got=%h exp=%h", c, fifo_wdata, ed[c]); end
      $display("early c=%0d req=%b ack=%b owner=%b", c, req, ack, owner);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_edge_inputs();
    logic [3:0] ea;
    do_reset();
    en = 1'b1; burst_len = 4'd0; req = 4'hF; fifo_full = 1'b0;
    for (int c = 0; c < 4; c++) begin
      ea = 4'b0001 << c;
      @(negedge clk);
      total++; if (ack !== ea) begin bad++; $display("FAIL blen0_ack c=%0d got=%b exp=%b", c, ack, ea); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL blen0_busy c=%0d got=%b exp=0", c, busy); end
      $display("blen0 c=%0d ack=%b busy=%b", c, ack, busy);
      @(posedge clk); #1;
    end
    en = 1'b0; burst_len = 4'd1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++; if (ack !== 4'b0000) begin bad++; $display("FAIL en0_ack c=%0d got=%b exp=0000", c, ack); end
      total++; if (fifo_wr !== 1'b0) begin bad++; $display("FAIL en0_wr c=%0d got=%b exp=0", c, fifo_wr); end
      total++; if (fifo_wdata !== 8'h00) begin bad++; $display("FAIL en0_wdata c=%0d got=%h exp=00", c, fifo_wdata); end
      $display("en0 c=%0d ack=%b wr=%b", c, ack, fifo_wr);
      @(posedge clk); #1;
    end
    en = 1'b1;
  endtask

  task automatic test_latch_blen();
    logic [3:0] bl [3];
    logic [3:0] ea [3];
    logic       eb [3];
    bl = '{4'd2, 4'd7, 4'd7};
    ea = '{4'h1, 4'h1, 4'h2};
    eb = '{1'b0, 1'b1, 1'b0};
    do_reset();
    en = 1'b1; req = 4'b0011; fifo_full = 1'b0;
    for (int c = 0; c < 3; c++) begin
      burst_len = bl[c];
      @(negedge clk);
      total++; if (ack !== ea[c]) begin bad++; $display("FAIL latch_ack c=%0d got=%b exp=%b", c, ack, ea[c]); end
      total++; if (busy !== eb[c]) begin bad++; $display("FAIL latch_busy c=%0d got=%b exp=%b", c, busy, eb[c]); end
      $display("latch c=%0d blen=%0d ack=%b busy=%b", c, burst_len, ack, busy);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    en = 1'b1; burst_len = 4'd3; req = 4'b0100; fifo_full = 1'b0;
    @(negedge clk);
    total++; if (ack !== 4'b0100) begin bad++; $display("FAIL mid_first_ack got=%b exp=0100", ack); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_async_busy got=%b exp=0", busy); end
    total++; if (owner !== 4'b0000) begin bad++; $display("FAIL mid_async_owner got=%b exp=0000", owner); end
    total++; if (ack !== 4'b0000) begin bad++; $display("FAIL mid_async_ack got=%b exp=0000", ack); end
    $display("reset mid-burst busy=%b owner=%b ack=%b", busy, owner, ack);
    @(posedge clk); #1;
    rst_n = 1'b1; req = 4'b0111;
    @(negedge clk);
    total++; if (ack !== 4'b0001) begin bad++; $display("FAIL mid_release_ack got=%b exp=0001", ack); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_release_busy got=%b exp=0", busy); end
    $display("after mid reset ack=%b busy=%b", ack, busy);
    @(posedge clk); #1;
  endtask

  initial begin
    req_data = 32'hA3A2A1A0;
    test_reset();
    test_rotation();
    test_burst();
    test_backpressure();
    test_early_release();
    test_edge_inputs();
    test_latch_blen();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
